// File: rtl/pq_pkg.sv
// pq_pkg: shared key/value type and round-robin pick helper for the priority-queue arbiter
package pq_pkg;
    localparam int KEY_WIDTH = 8;
    localparam int VAL_WIDTH = 8;
    localparam int MAX_REQ   = 32;
    typedef logic [KEY_WIDTH+VAL_WIDTH-1:0] kv_t;
    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
    } pick_t;
    // Descending scan so the lowest offset from ptr wins the final overwrite
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req, input int unsigned ptr,
                                      input int unsigned n);
        pick_t       p;
        int unsigned j;
        p = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            j = ptr + unsigned'(k);
            j = (j >= n) ? j - n : j;
            if (unsigned'(k) < n && req[j]) begin
                p.valid = 1'b1;
                p.idx   = 5'(j);
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/pq_arb_rr.sv
// rr_arb: combinational round-robin pick starting at ptr, one-hot grant plus index
module rr_arb
    import pq_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);
    pick_t p;
    always_comb begin
        p   = rr_pick(MAX_REQ'(req), unsigned'(32'(ptr)), unsigned'(N_REQ));
        vld = p.valid;
        idx = IDX_W'(p.idx);
        gnt = vld ? N_REQ'(1) << idx : '0;
    end
endmodule

// File: rtl/pq_arb.sv
// pq_arb: round-robin sharing of one priority queue among N_REQ requesters
// Independent enqueue/dequeue pointers; dequeued items return through a registered port.
module pq_arb
    import pq_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_enq,
    input  logic [N_REQ-1:0] req_deq,
    input  kv_t              req_kv [N_REQ],
    output logic [N_REQ-1:0] gnt_enq,
    output logic [N_REQ-1:0] gnt_deq,
    output logic [N_REQ-1:0] rsp_valid,
    output kv_t              rsp_kv,
    output logic             pq_enq,
    output logic             pq_deq,
    output kv_t              pq_kvi,
    input  kv_t              pq_kvo,
    input  logic             pq_full,
    input  logic             pq_empty
);
    logic [IDX_W-1:0] ptr_enq, ptr_deq, e_idx, d_idx;
    logic [N_REQ-1:0] e_gnt, d_gnt, rsp_q;
    logic             e_vld, d_vld, enq_ok, deq_ok;
    kv_t              rsp_kv_q;

    rr_arb #(.N_REQ(N_REQ)) u_enq (.req(req_enq), .ptr(ptr_enq), .gnt(e_gnt), .idx(e_idx), .vld(e_vld));
    rr_arb #(.N_REQ(N_REQ)) u_deq (.req(req_deq), .ptr(ptr_deq), .gnt(d_gnt), .idx(d_idx), .vld(d_vld));

    function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] i);
        return (32'(i) == N_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // A full queue still accepts an enqueue when a dequeue frees a slot in the same cycle
    always_comb begin
        deq_ok    = !rst && d_vld && !pq_empty;
        enq_ok    = !rst && e_vld && (!pq_full || deq_ok);
        gnt_enq   = enq_ok ? e_gnt : '0;
        gnt_deq   = deq_ok ? d_gnt : '0;
        pq_enq    = enq_ok;
        pq_deq    = deq_ok;
        pq_kvi    = enq_ok ? req_kv[e_idx] : '0;
        rsp_valid = rst ? '0 : rsp_q;
        rsp_kv    = rst ? '0 : rsp_kv_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_enq  <= '0;
            ptr_deq  <= '0;
            rsp_q    <= '0;
            rsp_kv_q <= '0;
        end else begin
            if (enq_ok) ptr_enq <= nxt(e_idx);
            if (deq_ok) begin
                ptr_deq  <= nxt(d_idx);
                rsp_kv_q <= pq_kvo;
            end
            rsp_q <= gnt_deq;
        end
    end
endmodule

// File: tb/tb_pq_arb.sv
// tb_pq_arb: randomized + directed scoreboard bench; the bench itself plays the priority queue
module tb_pq_arb;
    import pq_pkg::*;
    localparam int N = 4;
    localparam int CAP = 4;

    logic clk = 0, rst = 1;
    logic [N-1:0] req_enq = '0, req_deq = '0;
    kv_t req_kv [N];
    logic [N-1:0] gnt_enq, gnt_deq, rsp_valid;
    kv_t rsp_kv, pq_kvi, pq_kvo = '0;
    logic pq_enq, pq_deq, pq_full = 0, pq_empty = 1;

    always #5 clk = ~clk;

    pq_arb #(.N_REQ(N)) dut (
        .clk(clk), .rst(rst), .req_enq(req_enq), .req_deq(req_deq), .req_kv(req_kv),
        .gnt_enq(gnt_enq), .gnt_deq(gnt_deq), .rsp_valid(rsp_valid), .rsp_kv(rsp_kv),
        .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvi(pq_kvi), .pq_kvo(pq_kvo),
        .pq_full(pq_full), .pq_empty(pq_empty)
    );

    typedef struct {int who; kv_t kv; int due;} rsp_t;
    rsp_t sb[$];
    kv_t q[$];
    int vectors = 0, errors = 0, cyc = 0, pe = 0, pd = 0;
    logic [N-1:0] lg_e, lg_d;
    bit done = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int pick(logic [N-1:0] r, int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic int minpos();
        int m = 0;
        for (int i = 1; i < q.size(); i++)
            if (q[i][KEY_WIDTH+VAL_WIDTH-1:VAL_WIDTH] < q[m][KEY_WIDTH+VAL_WIDTH-1:VAL_WIDTH]) m = i;
        return m;
    endfunction

    task automatic upd();
        pq_empty = (q.size() == 0);
        pq_full  = (q.size() >= CAP);
        pq_kvo   = pq_empty ? '0 : q[minpos()];
    endtask

    task automatic step();
        int we, wd, m;
        bit ge, gd;
        kv_t xkv;
        @(negedge clk);
        we = pick(req_enq, pe);
        wd = pick(req_deq, pd);
        gd = !rst && wd >= 0 && q.size() > 0;
        ge = !rst && we >= 0 && (q.size() < CAP || gd);
        xkv = ge ? req_kv[we] : '0;
        chk("gnt_enq", gnt_enq, ge ? (64'd1 << we) : 64'd0);
        chk("gnt_deq", gnt_deq, gd ? (64'd1 << wd) : 64'd0);
        chk("pq_enq", pq_enq, ge);
        chk("pq_deq", pq_deq, gd);
        chk("pq_kvi", pq_kvi, xkv);
        lg_e = gnt_enq;
        lg_d = gnt_deq;
        @(posedge clk);
        cyc++;
        if (rst) begin
            pe = 0;
            pd = 0;
        end else begin
            if (gd) begin
                m = minpos();
                sb.push_back('{wd, q[m], cyc});
                q.delete(m);
                pd = (wd + 1) % N;
            end
            if (ge) begin
                q.push_back(req_kv[we]);
                pe = (we + 1) % N;
            end
        end
        #1;
        if (ge) req_enq[we] = 0;
        if (gd) req_deq[wd] = 0;
        upd();
    endtask

    // Monitor: pops the scoreboard whenever a response is due
    initial begin
        while (!done) begin
            @(negedge clk);
            if (rst) begin
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_kv", rsp_kv, 0);
                while (sb.size() > 0 && sb[0].due <= cyc) void'(sb.pop_front());
            end else if (sb.size() > 0 && sb[0].due == cyc) begin
                chk("rsp_valid", rsp_valid, 64'd1 << sb[0].who);
                chk("rsp_kv", rsp_kv, sb[0].kv);
                void'(sb.pop_front());
            end else begin
                chk("rsp_idle", rsp_valid, 0);
            end
        end
    end

    initial begin
        logic [7:0] keys [4];
        logic [7:0] sorted [4];
        keys = '{8'd5, 8'd3, 8'd7, 8'd1};
        sorted = '{8'd1, 8'd3, 8'd5, 8'd7};
        for (int i = 0; i < N; i++) req_kv[i] = '0;
        // reset then idle
        rst = 1;
        step();
        step();
        rst = 0;
        step();
        chk("idle_rsp_kv", rsp_kv, 0);
        // enqueue fairness
        for (int i = 0; i < N; i++) req_kv[i] = {keys[i], 8'(i)};
        req_enq = 4'b1111;
        for (int i = 0; i < N; i++) begin
            step();
            chk("fair_gnt_enq", lg_e, 64'd1 << i);
        end
        for (int i = 0; i < 4; i++) begin
            req_deq[2] = 1;
            step();
            chk("fair_gnt_deq", lg_d, 4'b0100);
            chk("fair_key", rsp_kv[15:8], sorted[i]);
        end
        // full queue
        q = '{16'h2001, 16'h2102, 16'h2203, 16'h2304};
        upd();
        req_enq[1] = 1;
        req_kv[1] = 16'h4040;
        step();
        chk("full_no_gnt", lg_e, 0);
        req_deq[3] = 1;
        step();
        chk("full_gnt_enq", lg_e, 4'b0010);
        chk("full_gnt_deq", lg_d, 4'b1000);
        // empty queue with both request types
        q.delete();
        upd();
        req_enq[0] = 1;
        req_kv[0] = {8'd1, 8'd11};
        req_deq[2] = 1;
        step();
        chk("empty_gnt_enq", lg_e, 4'b0001);
        chk("empty_gnt_deq", lg_d, 0);
        step();
        chk("empty_gnt_deq2", lg_d, 4'b0100);
        chk("empty_rsp_valid", rsp_valid, 4'b0100);
        chk("empty_rsp_kv", rsp_kv, {8'd1, 8'd11});
        // pointer wrap: ptr_deq is 3 here
        q = '{16'h1000, 16'h1100, 16'h1200};
        upd();
        for (int i = 0; i < 3; i++) begin
            req_deq = 4'b1001;
            step();
            chk("wrap_gnt_deq", lg_d, (i == 1) ? 4'b0001 : 4'b1000);
        end
        req_deq = '0;
        // reset mid-dequeue
        q = '{16'h5566};
        upd();
        req_deq[1] = 1;
        step();
        rst = 1;
        step();
        rst = 0;
        step();
        chk("midrst_rsp_kv", rsp_kv, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req_enq[i] && $urandom_range(0, 2) == 0) begin
                    req_enq[i] = 1;
                    req_kv[i] = {8'($urandom), 8'($urandom)};
                end
                if (!req_deq[i] && $urandom_range(0, 2) == 0) req_deq[i] = 1;
            end
            step();
        end
        rst = 0;
        req_enq = '0;
        req_deq = '0;
        for (int i = 0; i < 3; i++) step();
        chk("sb_drained", sb.size(), 0);
        done = 1;
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
